sha256_msg_padder: RTL and testbench
====================================

// Module: sha256_msg_padder
// PURPOSE
//  Initiator side of the SHA-256 block interface. Accepts a message as 32-bit big-endian words.
//  Applies FIPS 180-4 padding (0x80, zeros, 64-bit bit length) and emits 512-bit blocks with blk_new.
//  Its block port connects directly to the sha256 core's in/in_valid/new_hash/in_ready.
// PARAMETERS
//  LEN_W  64  bit-length counter width (3..64); wraps mod 2^LEN_W; zero-extended into words 14-15
// PORTS
//  clk_i      in   1    clock; one clock domain
//  rst_i      in   1    reset, asynchronous, active-high
//  in_valid   in   1    message word valid
//  in_data    in   32   message word, first byte in [31:24]
//  in_last    in   1    final word of message
//  in_nbytes  in   3    valid bytes (0..4) in final word, MSB-aligned; ignored (=4) when !in_last
//  in_ready   out  1    word accepted when in_valid&&in_ready
//  blk_valid  out  1    block valid (to core in_valid)
//  blk_data   out  512  block, word0 in [511:480] (to core in)
//  blk_new    out  1    first block of a message (to core new_hash)
//  blk_ready  in   1    block accepted when blk_valid&&blk_ready (from core in_ready)
// BEHAVIOUR
//  Reset values: state=FILL, widx=0, bitlen=0, first=1, buffer=0, blk_valid=0, blk_new=0; in_ready=1.
//  in_ready = (state==FILL), combinational. Reset mid-operation drops the message and any pending block.
//  FILL: each accepted word goes to buffer[widx]; widx++; bitlen += 8*bytes.
//   Non-last word at widx==15 -> EMIT, more=DATA (blk_valid next cycle).
//   Last word: writes bytes, 0x80 at byte nbytes, zeros below; nbytes==4 puts 0x80 in word widx+1.
//   Then p = index of the word holding 0x80 (p==16 when it spills past the block).
//   p<=13: clear words p+1..13, words 14-15 = bitlen incl. final bytes -> EMIT, more=NONE.
//   p>=14: clear words p+1..15 -> EMIT, more=LEN; p==16 also sets carry80.
//  EMIT: blk_valid=1; blk_data/blk_new held stable until blk_ready. On handshake:
//   more=DATA: widx=0, first=0 -> FILL.
//   more=LEN: build block with word0=carry80?0x80000000:0, zeros, words14-15=bitlen; first=0 -> EMIT, more=NONE.
//   more=NONE: widx=0, bitlen=0, first=1, carry80=0 -> FILL.
//  blk_new = first at EMIT entry, so it is 1 only on a message's first block.
//  in_last with in_nbytes==0 at widx==0 is legal: empty message or exact multiple of 4 bytes.
//  One block transferred per EMIT cycle with blk_ready=1. Data blocks: 16 accept cycles + 1 emit cycle.
//  Back-to-back messages: the next message's first word is accepted the cycle after the final handshake.
// CONFIGURATION
//  SHA256_PAD_ABORT_EN defined: adds input abort_i (1b). When high in any state:
//   widx=0, bitlen=0, first=1, blk_valid=0 -> FILL next cycle; a word presented that cycle is dropped.
//   abort_i outranks a simultaneous block handshake, which is discarded.
//  Undefined: no abort_i port; a message can only be cancelled by rst_i.
// STRUCTURE
//  sha256_pkg: state enum {FILL,EMIT}, more enum {NONE,DATA,LEN}, blk_t (16x32 words),
//   H0..H7 initial constants (shared with the core).
//  Sub-module sha256_pad_word: combinational; (data, nbytes) -> padded word + spill flag.
// TESTING
//  "abc": one word 0x61626300, nbytes=3, last -> 1 block, new=1; w0=0x61626380, w1..w14=0, w15=0x18.
//  Empty: in_data=0, nbytes=0, last at widx0 -> w0=0x80000000, all others 0, new=1.
//  56 bytes (14 words, last nbytes=4) -> blk1 w14=0x80000000, w15=0, new=1; blk2 w15=0x1C0, new=0.
//  64 bytes -> blk1 data, new=1; blk2 w0=0x80000000, w15=0x200, new=0.
//  blk_ready low 5 cycles in EMIT -> blk_data/blk_new stable, in_ready=0; release -> one transfer only.
//  rst_i pulse mid-EMIT -> blk_valid=0 immediately; "abc" afterwards -> correct block with new=1.
//  Abort (SHA256_PAD_ABORT_EN): abort_i at widx=7 -> no block emitted; next "abc" -> new=1, w15=0x18.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared SHA-256 types and constants: padder FSM enums, block container,
// initial hash values H0..H7 and a block packing helper.
package sha256_pkg;

    typedef enum logic {FILL, EMIT} state_e;
    typedef enum logic [1:0] {NONE, DATA, LEN} more_e;

    typedef logic [31:0] blk_t [16];

    localparam logic [31:0] H0 = 32'h6a09_e667;
    localparam logic [31:0] H1 = 32'hbb67_ae85;
    localparam logic [31:0] H2 = 32'h3c6e_f372;
    localparam logic [31:0] H3 = 32'ha54f_f53a;
    localparam logic [31:0] H4 = 32'h510e_527f;
    localparam logic [31:0] H5 = 32'h9b05_688c;
    localparam logic [31:0] H6 = 32'h1f83_d9ab;
    localparam logic [31:0] H7 = 32'h5be0_cd19;

    // Word 0 lands in the most significant 32 bits of the flat block.
    function automatic logic [511:0] pack_blk(input blk_t b);
        logic [511:0] r;
        r = 512'h0;
        for (int i = 0; i < 16; i++) begin
            r[511-32*i -: 32] = b[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/sha256_pad_word.sv
// Pads one big-endian message word: keeps nbytes leading bytes, inserts 0x80
// after them and zeroes the rest; spill flags that 0x80 belongs in the next word.
module sha256_pad_word (
    input  logic [31:0] data_i,
    input  logic [2:0]  nbytes_i,
    output logic [31:0] word_o,
    output logic        spill_o
);

    // Byte-wise select between data, the 0x80 marker and zero.
    always_comb begin
        word_o  = 32'h0;
        spill_o = (nbytes_i >= 3'd4);
        for (int b = 0; b < 4; b++) begin
            if (3'(b) < nbytes_i) begin
                word_o[31-8*b -: 8] = data_i[31-8*b -: 8];
            end else if (3'(b) == nbytes_i) begin
                word_o[31-8*b -: 8] = 8'h80;
            end else begin
                word_o[31-8*b -: 8] = 8'h00;
            end
        end
    end

endmodule

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: packs 32-bit words into FIPS 180-4 padded 512-bit blocks.
// Optional abort_i input is present when SHA256_PAD_ABORT_EN is defined.
module sha256_msg_padder
    import sha256_pkg::*;
#(
    parameter int LEN_W = 64
) (
    input  logic         clk_i,
    input  logic         rst_i,
`ifdef SHA256_PAD_ABORT_EN
    input  logic         abort_i,
`endif
    input  logic         in_valid,
    input  logic [31:0]  in_data,
    input  logic         in_last,
    input  logic [2:0]   in_nbytes,
    output logic         in_ready,
    output logic         blk_valid,
    output logic [511:0] blk_data,
    output logic         blk_new,
    input  logic         blk_ready
);

    state_e           state_q, state_d;
    more_e            more_q, more_d;
    logic [3:0]       widx_q, widx_d;
    logic [LEN_W-1:0] bitlen_q, bitlen_d, bitlen_sum_s;
    logic             first_q, first_d;
    logic             carry80_q, carry80_d;
    logic             blk_valid_q, blk_valid_d;
    logic             blk_new_q, blk_new_d;
    blk_t             buf_q, buf_d;
    logic [2:0]       nb_eff_s, bytes_s;
    logic [31:0]      pad_word_s;
    logic             spill_s;
    logic [4:0]       p_s;
    logic [63:0]      len_s, len_next_s;

    assign nb_eff_s     = in_last ? in_nbytes : 3'd4;
    assign bytes_s      = spill_s ? 3'd4 : nb_eff_s;
    assign bitlen_sum_s = bitlen_q + LEN_W'({bytes_s, 3'b000});
    assign len_s        = 64'(bitlen_q);
    assign len_next_s   = 64'(bitlen_sum_s);
    assign p_s          = {1'b0, widx_q} + {4'b0000, spill_s};

    sha256_pad_word u_pad (
        .data_i  (in_data),
        .nbytes_i(nb_eff_s),
        .word_o  (pad_word_s),
        .spill_o (spill_s)
    );

    assign in_ready  = (state_q == FILL);
    assign blk_valid = blk_valid_q;
    assign blk_new   = blk_new_q;

    // Flatten the held block buffer onto the block port.
    always_comb begin
        blk_data = pack_blk(buf_q);
    end

    // State and buffer registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= FILL;
            more_q      <= NONE;
            widx_q      <= 4'd0;
            bitlen_q    <= '0;
            first_q     <= 1'b1;
            carry80_q   <= 1'b0;
            blk_valid_q <= 1'b0;
            blk_new_q   <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                buf_q[i] <= 32'h0;
            end
        end else begin
            state_q     <= state_d;
            more_q      <= more_d;
            widx_q      <= widx_d;
            bitlen_q    <= bitlen_d;
            first_q     <= first_d;
            carry80_q   <= carry80_d;
            blk_valid_q <= blk_valid_d;
            blk_new_q   <= blk_new_d;
            buf_q       <= buf_d;
        end
    end

    // Next-state: fill words, pad the final word, then present blocks until accepted.
    always_comb begin
        state_d     = state_q;
        more_d      = more_q;
        widx_d      = widx_q;
        bitlen_d    = bitlen_q;
        first_d     = first_q;
        carry80_d   = carry80_q;
        blk_valid_d = blk_valid_q;
        blk_new_d   = blk_new_q;
        buf_d       = buf_q;

        case (state_q)
            FILL: begin
                if (in_valid) begin
                    bitlen_d = bitlen_sum_s;
                    if (!in_last) begin
                        buf_d[widx_q] = pad_word_s;
                        if (widx_q == 4'd15) begin
                            state_d     = EMIT;
                            more_d      = DATA;
                            blk_valid_d = 1'b1;
                            blk_new_d   = first_q;
                        end else begin
                            widx_d = widx_q + 4'd1;
                        end
                    end else begin
                        // p_s is the word holding 0x80; everything after it is cleared.
                        for (int i = 0; i < 16; i++) begin
                            if (5'(i) < {1'b0, widx_q}) begin
                                buf_d[i] = buf_q[i];
                            end else if (5'(i) == {1'b0, widx_q}) begin
                                buf_d[i] = pad_word_s;
                            end else if (5'(i) == p_s) begin
                                buf_d[i] = 32'h8000_0000;
                            end else begin
                                buf_d[i] = 32'h0;
                            end
                        end
                        if (p_s <= 5'd13) begin
                            buf_d[14] = len_next_s[63:32];
                            buf_d[15] = len_next_s[31:0];
                            more_d    = NONE;
                        end else begin
                            more_d = LEN;
                        end
                        carry80_d   = (p_s == 5'd16);
                        state_d     = EMIT;
                        blk_valid_d = 1'b1;
                        blk_new_d   = first_q;
                    end
                end else begin
                    state_d = FILL;
                end
            end
            EMIT: begin
                if (blk_ready) begin
                    case (more_q)
                        DATA: begin
                            widx_d      = 4'd0;
                            first_d     = 1'b0;
                            more_d      = NONE;
                            state_d     = FILL;
                            blk_valid_d = 1'b0;
                            blk_new_d   = 1'b0;
                        end
                        LEN: begin
                            for (int i = 0; i < 16; i++) begin
                                buf_d[i] = 32'h0;
                            end
                            buf_d[0]  = carry80_q ? 32'h8000_0000 : 32'h0;
                            buf_d[14] = len_s[63:32];
                            buf_d[15] = len_s[31:0];
                            first_d   = 1'b0;
                            carry80_d = 1'b0;
                            more_d    = NONE;
                            blk_new_d = 1'b0;
                        end
                        NONE: begin
                            widx_d      = 4'd0;
                            bitlen_d    = '0;
                            first_d     = 1'b1;
                            carry80_d   = 1'b0;
                            state_d     = FILL;
                            blk_valid_d = 1'b0;
                            blk_new_d   = 1'b0;
                        end
                        default: begin
                            state_d     = FILL;
                            more_d      = NONE;
                            blk_valid_d = 1'b0;
                        end
                    endcase
                end else begin
                    state_d = EMIT;
                end
            end
            default: begin
                state_d     = FILL;
                blk_valid_d = 1'b0;
            end
        endcase

`ifdef SHA256_PAD_ABORT_EN
        // Abort wins over any accept or block handshake in the same cycle.
        if (abort_i) begin
            state_d     = FILL;
            more_d      = NONE;
            widx_d      = 4'd0;
            bitlen_d    = '0;
            first_d     = 1'b1;
            carry80_d   = 1'b0;
            blk_valid_d = 1'b0;
            blk_new_d   = 1'b0;
            buf_d       = buf_q;
        end else begin
            state_d = state_d;
        end
`endif
    end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Scoreboard bench for sha256_msg_padder: expected blocks are queued as
// messages are issued, a negedge monitor pops and compares on each handshake.
module tb_sha256_msg_padder;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic [31:0]  in_data = 32'h0;
    logic         in_last = 1'b0;
    logic [2:0]   in_nbytes = 3'd0;
    logic         in_ready;
    logic         blk_valid;
    logic [511:0] blk_data;
    logic         blk_new;
    logic         blk_ready = 1'b1;
`ifdef SHA256_PAD_ABORT_EN
    logic         abort_i = 1'b0;
`endif

    typedef struct {
        logic [511:0] data;
        logic         nw;
    } exp_t;

    exp_t       exp_q[$];
    int         n_pass = 0;
    int         n_total = 0;
    logic [7:0] msg [132];

    sha256_msg_padder #(.LEN_W(64)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
`ifdef SHA256_PAD_ABORT_EN
        .abort_i  (abort_i),
`endif
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_last  (in_last),
        .in_nbytes(in_nbytes),
        .in_ready (in_ready),
        .blk_valid(blk_valid),
        .blk_data (blk_data),
        .blk_new  (blk_new),
        .blk_ready(blk_ready)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Monitor: a block seen valid&&ready at negedge is transferred on the next posedge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && blk_valid && blk_ready) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_block: got %h expected none", blk_data);
            end else begin
                e = exp_q.pop_front();
                chk("blk_data", blk_data, e.data);
                chk("blk_new", 512'(blk_new), 512'(e.nw));
            end
        end
    end

    task automatic send_word(input logic [31:0] d, input logic last, input logic [2:0] nb);
        int n;
        n = 0;
        in_valid = 1'b1; in_data = d; in_last = last; in_nbytes = nb;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            n_total++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
        end
        @(posedge clk); #1;
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < 500) begin
            n++;
            @(negedge clk);
        end
        if (exp_q.size() > 0) begin
            n_total++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic set_msg(input int n, input int seed);
        for (int k = 0; k < 132; k++) begin
            msg[k] = (k < n) ? 8'(k + seed) : 8'hEE;
        end
    endtask

    // Queue expected blocks (0x80 at byte n, hand-given length word at the end), then send.
    task automatic run_msg(input int n, input logic zero_tail, input logic [31:0] len_lo, input int nblk);
        logic [7:0] pb [128];
        exp_t       e;
        int         nfull;
        int         rem;
        for (int j = 0; j < 128; j++) pb[j] = (j < n) ? msg[j] : 8'h00;
        pb[n] = 8'h80;
        for (int j = 0; j < 4; j++) pb[nblk*64-4+j] = len_lo[31-8*j -: 8];
        for (int b = 0; b < nblk; b++) begin
            e.data = 512'h0;
            for (int j = 0; j < 64; j++) e.data[511-8*j -: 8] = pb[b*64+j];
            e.nw = (b == 0);
            exp_q.push_back(e);
        end
        nfull = n / 4;
        rem   = n % 4;
        if (rem == 0 && !zero_tail && n > 0) begin
            for (int w = 0; w < nfull; w++)
                send_word({msg[4*w], msg[4*w+1], msg[4*w+2], msg[4*w+3]}, (w == nfull-1), 3'd4);
        end else begin
            for (int w = 0; w < nfull; w++)
                send_word({msg[4*w], msg[4*w+1], msg[4*w+2], msg[4*w+3]}, 1'b0, 3'd4);
            send_word({msg[4*nfull], msg[4*nfull+1], msg[4*nfull+2], msg[4*nfull+3]}, 1'b1, 3'(rem));
        end
        wait_drain();
    endtask

    task automatic set_abc();
        set_msg(0, 0);
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
    endtask

    initial begin
        int n;
        logic [511:0] abc_blk;
        abc_blk = 512'h0;
        abc_blk[511:480] = 32'h6162_6380;
        abc_blk[31:0]    = 32'h0000_0018;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", 512'(in_ready), 512'h1);
        chk("reset_blk_valid", 512'(blk_valid), 512'h0);
        chk("reset_blk_new", 512'(blk_new), 512'h0);
        chk("reset_blk_data", blk_data, 512'h0);
        @(posedge clk); #1;

        set_abc();           run_msg(3, 1'b0, 32'h18, 1);
        set_msg(0, 0);       run_msg(0, 1'b1, 32'h0, 1);
        set_msg(5, 8'h68);   run_msg(5, 1'b0, 32'h28, 1);
        set_msg(4, 8'h61);   run_msg(4, 1'b1, 32'h20, 1);
        set_msg(55, 1);      run_msg(55, 1'b0, 32'h1B8, 1);
        set_msg(56, 1);      run_msg(56, 1'b0, 32'h1C0, 2);
        set_msg(60, 3);      run_msg(60, 1'b0, 32'h1E0, 2);
        set_msg(63, 5);      run_msg(63, 1'b0, 32'h1F8, 2);
        set_msg(64, 9);      run_msg(64, 1'b0, 32'h200, 2);
        set_msg(64, 2);      run_msg(64, 1'b1, 32'h200, 2);

        // Back-pressure: block must hold steady while blk_ready is low.
        blk_ready = 1'b0;
        set_abc();
        exp_q.push_back('{data: abc_blk, nw: 1'b1});
        send_word(32'h6162_63EE, 1'b1, 3'd3);
        n = 0;
        while (!blk_valid && n < 50) begin n++; @(negedge clk); end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("stall_blk_valid", 512'(blk_valid), 512'h1);
            chk("stall_blk_data", blk_data, abc_blk);
            chk("stall_blk_new", 512'(blk_new), 512'h1);
            chk("stall_in_ready", 512'(in_ready), 512'h0);
        end
        @(posedge clk); #1 blk_ready = 1'b1;
        wait_drain();
        repeat (3) begin
            @(negedge clk);
            chk("post_stall_blk_valid", 512'(blk_valid), 512'h0);
        end

        // Reset while a block is pending.
        blk_ready = 1'b0;
        @(posedge clk); #1;
        send_word(32'h1122_3300, 1'b1, 3'd3);
        n = 0;
        while (!blk_valid && n < 50) begin n++; @(negedge clk); end
        chk("pre_reset_blk_valid", 512'(blk_valid), 512'h1);
        rst = 1'b1;
        #1;
        chk("reset_mid_emit_blk_valid", 512'(blk_valid), 512'h0);
        @(posedge clk); #1 rst = 1'b0;
        blk_ready = 1'b1;
        set_abc();           run_msg(3, 1'b0, 32'h18, 1);

`ifdef SHA256_PAD_ABORT_EN
        // Abort after seven words; the word presented with abort is dropped.
        set_msg(40, 1);
        for (int w = 0; w < 7; w++)
            send_word({msg[4*w], msg[4*w+1], msg[4*w+2], msg[4*w+3]}, 1'b0, 3'd4);
        abort_i = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD_BEEF; in_last = 1'b1; in_nbytes = 3'd4;
        @(posedge clk); #1;
        abort_i = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        @(negedge clk);
        chk("abort_blk_valid", 512'(blk_valid), 512'h0);
        chk("abort_in_ready", 512'(in_ready), 512'h1);
        @(posedge clk); #1;
        set_abc();           run_msg(3, 1'b0, 32'h18, 1);
`endif

        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
